// File: rtl/sdram_loader_if.sv
// Toggle-handshake SDRAM host port shared by the loader (device side) and the controller.
// A request is outstanding while req != ack; address/data_write/we stay stable until ack catches up.
interface sdram_bus #(
    parameter int ADDR_BITS = 24
);
    logic                 req;
    logic                 we;
    logic [ADDR_BITS-1:0] address;
    logic [15:0]          data_write;
    logic                 ack;
    logic [15:0]          data_read;

    modport device (
        output req, we, address, data_write,
        input  ack, data_read
    );

    modport controller (
        input  req, we, address, data_write,
        output ack, data_read
    );
endinterface

// File: rtl/sdram_loader.sv
// Packs an API byte stream into little-endian 16-bit SDRAM writes on a toggle req/ack port.
// Optional macro SDRAM_LOADER_CHECKSUM_EN adds a 16-bit running sum of issued words.
module sdram_loader #(
    parameter int ADDR_BITS = 24,
    parameter int LEN_BITS  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]  byte_count,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
`ifdef SDRAM_LOADER_CHECKSUM_EN
    output logic [15:0]          checksum,
`endif
    sdram_bus.device             mem
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [LEN_BITS-1:0]  LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};

    logic [1:0]           state;
    logic [ADDR_BITS-1:0] next_addr;
    logic [LEN_BITS-1:0]  remaining;
    logic [7:0]           lo_byte;
    logic                 have_lo;
    logic [15:0]          pend_word;
    logic                 pend_valid;
    logic                 bus_idle;
    logic                 accept;
    logic                 issue;
    logic                 unused_read;

    assign unused_read = ^mem.data_read;
    assign bus_idle    = (mem.req == mem.ack);

    // Abort wins over a byte offered in the same cycle, so in_ready drops combinationally.
    assign in_ready = (state == S_RUN) && !pend_valid && (remaining != '0) && !abort;
    assign accept   = in_valid && in_ready;
    assign issue    = (state == S_RUN) && pend_valid && bus_idle && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            next_addr      <= '0;
            remaining      <= '0;
            lo_byte        <= '0;
            have_lo        <= 1'b0;
            pend_word      <= '0;
            pend_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem.req        <= 1'b0;
            mem.we         <= 1'b0;
            mem.address    <= '0;
            mem.data_write <= '0;
`ifdef SDRAM_LOADER_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef SDRAM_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (byte_count != '0) begin
                            next_addr <= base_addr;
                            remaining <= byte_count;
                            busy      <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        pend_valid <= 1'b0;
                        have_lo    <= 1'b0;
                        remaining  <= '0;
                        state      <= S_DRAIN;
                    end else begin
                        if (issue) begin
                            mem.req        <= ~mem.req;
                            mem.we         <= 1'b1;
                            mem.address    <= next_addr;
                            mem.data_write <= pend_word;
                            next_addr      <= next_addr + ADDR_ONE;
                            pend_valid     <= 1'b0;
`ifdef SDRAM_LOADER_CHECKSUM_EN
                            checksum       <= checksum + pend_word;
`endif
                        end
                        // accept and issue are exclusive: accept needs an empty pending slot.
                        if (accept) begin
                            remaining <= remaining - LEN_ONE;
                            if (have_lo) begin
                                pend_word  <= {in_data, lo_byte};
                                pend_valid <= 1'b1;
                                have_lo    <= 1'b0;
                            end else if (remaining == LEN_ONE) begin
                                pend_word  <= {8'h00, in_data};
                                pend_valid <= 1'b1;
                            end else begin
                                lo_byte <= in_data;
                                have_lo <= 1'b1;
                            end
                        end
                        if ((remaining == '0) && !pend_valid && bus_idle) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    if (bus_idle) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_loader.sv
// Randomized bench for sdram_loader: a word-level model of the byte stream feeds an expected-write
// queue, and a controller model acks requests and checks the bus every cycle.
module tb_sdram_loader;
    localparam int AB = 24;
    localparam int LB = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [LB-1:0] byte_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          busy;
    logic          done;
`ifdef SDRAM_LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    sdram_bus #(.ADDR_BITS(AB)) mem ();

    sdram_loader #(.ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
`ifdef SDRAM_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .mem        (mem)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  stim[$];
    int          ack_dly = 3;
    bit          outstanding = 1'b0;
    int          ack_cnt = 0;
    int          issued = 0;
    int          done_cnt = 0;
    logic [AB-1:0] held_addr = '0;
    logic [15:0]   held_data = '0;
    logic [AB-1:0] last_addr = '0;
    logic [15:0]   last_data = '0;
    logic [15:0]   model_sum = '0;
    int            probe_idx = -1;
    logic          probe_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Word view of the stream: pairs of bytes little-endian, odd tail padded with 0x00.
    task automatic build_exp(input logic [AB-1:0] b);
        logic [7:0]    lo, hi;
        logic [AB-1:0] a;
        int            k;
        k = 0;
        model_sum = '0;
        for (int i = 0; i < stim.size(); i += 2) begin
            lo = stim[i];
            hi = (i + 1 < stim.size()) ? stim[i+1] : 8'h00;
            a  = b + AB'(k);
            exp_q.push_back({a, hi, lo});
            model_sum = model_sum + {hi, lo};
            k++;
        end
    endtask

    // SDRAM controller model and per-cycle bus checker.
    initial begin
        mem.ack = 1'b0;
        mem.data_read = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem.ack = 1'b0;
                outstanding = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    check("done_implies_idle", {busy, in_ready}, 2'b00);
                end
                if (in_ready) check("ready_implies_busy", busy, 1'b1);
                if (outstanding) begin
                    check("busy_while_outstanding", busy, 1'b1);
                    check("hold_stable", {mem.we, mem.address, mem.data_write}, {1'b1, held_addr, held_data});
                    if (ack_cnt <= 0) begin
                        mem.ack = mem.req;
                        outstanding = 1'b0;
                    end else begin
                        ack_cnt--;
                    end
                end else if (mem.req != mem.ack) begin
                    issued++;
                    check("we_on_issue", mem.we, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write addr=%0h data=%0h", mem.address, mem.data_write);
                    end else begin
                        check("write_addr_data", {mem.address, mem.data_write}, exp_q.pop_front());
                    end
                    held_addr   = mem.address;
                    held_data   = mem.data_write;
                    last_addr   = mem.address;
                    last_data   = mem.data_write;
                    outstanding = 1'b1;
                    ack_cnt     = (ack_dly < 0) ? int'($urandom_range(0, 6)) : ack_dly;
                end
            end
        end
    end

    task automatic run_xfer(input logic [AB-1:0] b, input int dly, input int vprob, input int abort_at);
        int idx, cyc, n, done0, iss0;
        bit fin, aborted;
        idx = 0; cyc = 0; fin = 1'b0; aborted = 1'b0;
        n = stim.size();
        ack_dly = dly;
        build_exp(b);
        done0 = done_cnt;
        iss0  = issued;
        probe_idx = -1;
        @(posedge clk); #1;
        base_addr  = b;
        byte_count = LB'(n);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        @(posedge clk); #1;
        while (!fin && cyc < 4000) begin
            abort = 1'b0;
            if (abort_at >= 0 && !aborted && idx == abort_at && outstanding) begin
                abort    = 1'b1;
                aborted  = 1'b1;
                in_valid = 1'b1;
                in_data  = stim[idx];
            end else begin
                in_valid = (!aborted && idx < n) ? ($urandom_range(0, 99) < vprob) : 1'b0;
                if (idx < n) in_data = stim[idx];
            end
            @(negedge clk);
            if (abort) check("ready_low_on_abort", in_ready, 1'b0);
            if (in_valid && in_ready) idx++;
            if (cyc == 12) begin
                probe_idx = idx;
                probe_rdy = in_ready;
            end
            if (aborted ? !busy : done) fin = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        in_valid = 1'b0;
        check("xfer_finished", fin, 1'b1);
        if (aborted) begin
            check("abort_no_done", done_cnt - done0, 0);
            check("abort_words_issued", issued - iss0, abort_at / 2);
            exp_q.delete();
        end else begin
            check("bytes_consumed", idx, n);
            check("all_words_written", exp_q.size(), 0);
            check("one_done", done_cnt - done0, 1);
            check("busy_after_done", busy, 1'b0);
`ifdef SDRAM_LOADER_CHECKSUM_EN
            check("checksum", checksum, model_sum);
`endif
        end
        check("bus_idle_after", mem.req == mem.ack, 1'b1);
        exp_q.delete();
    endtask

    initial begin
        int iss0, done0;
        logic req0;
        #12;
        check("rst_bus", {mem.req, mem.we, mem.address, mem.data_write}, 0);
        check("rst_flags", {in_ready, busy, done}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Even stream with hand-computed writes.
        stim = {8'h11, 8'h22, 8'h33, 8'h44};
        run_xfer(24'h000100, 3, 100, -1);
        check("even_last_addr", last_addr, 24'h000101);
        check("even_last_data", last_data, 16'h4433);

        // Odd tail.
        stim = {8'hAA, 8'hBB, 8'hCC};
        run_xfer(24'h000200, 2, 70, -1);
        check("odd_model_sum", model_sum, 16'hBC76);
        check("odd_last_addr", last_addr, 24'h000201);
        check("odd_last_data", last_data, 16'h00CC);

        // Zero length.
        iss0 = issued; done0 = done_cnt; req0 = mem.req;
        @(posedge clk); #1;
        byte_count = '0; start = 1'b1;
        @(negedge clk);
        check("zero_no_early_done", done, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done_pulse", {done, busy}, 2'b10);
        @(negedge clk);
        check("zero_done_one_cycle", {done, busy}, 2'b00);
        check("zero_req_unchanged", mem.req, req0);
        check("zero_no_issue", issued - iss0, 0);
        check("zero_one_done", done_cnt - done0, 1);
`ifdef SDRAM_LOADER_CHECKSUM_EN
        check("zero_checksum", checksum, 16'h0000);
`endif

        // Backpressure: long ack, stream always valid.
        stim = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_xfer(24'h001000, 20, 100, -1);
        check("bp_buffered_bytes", probe_idx, 4);
        check("bp_ready_low", probe_rdy, 1'b0);

        // Abort after 5 of 8 bytes with a request outstanding.
        stim = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        run_xfer(24'h002000, 10, 100, 5);
        check("abort_busy_low", busy, 1'b0);

        // Address wrap.
        stim = {8'h10, 8'h20, 8'h30, 8'h40};
        run_xfer(24'hFFFFFF, -1, 80, -1);
        check("wrap_addr", last_addr, 24'h000000);
        check("wrap_data", last_data, 16'h4030);

        // Randomized transfers.
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 12);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            run_xfer(AB'($urandom), -1, $urandom_range(30, 100), -1);
        end

        // Asynchronous reset mid-transfer.
        stim = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        build_exp(24'h000050);
        ack_dly = 30;
        @(posedge clk); #1;
        base_addr = 24'h000050; byte_count = 24'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bus", {mem.req, mem.we, mem.address, mem.data_write}, 0);
        check("midrst_flags", {in_ready, busy, done}, 3'b000);
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {busy, mem.req, mem.ack}, 3'b000);

        // Loader still works after reset.
        stim = {8'hDE, 8'hAD, 8'hBE};
        run_xfer(24'h000300, 1, 90, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end
endmodule
